serial_subtractor: RTL and testbench

//  Bit-serial two's-complement subtractor: computes A - B as A + ~B + 1, one bit per cycle,
//  LSB first, through a single full-adder cell with a registered carry.

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: A - B computed LSB first as A + ~B + 1
// through one full-adder cell, with start/busy/done handshake and NZCV flags.
module serial_subtractor #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, nb_sr;
  logic [WIDTH-2:0] res_part;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             c_q, c_next, s;
  logic             accept, step, last;

  // Single full-adder cell; the new sum bit enters the result from the MSB side.
  assign s        = a_sr[0] ^ nb_sr[0] ^ c_q;
  assign c_next   = (a_sr[0] & nb_sr[0]) | (a_sr[0] & c_q) | (nb_sr[0] & c_q);
  assign res_next = {s, res_part};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr     <= '0;
      nb_sr    <= '0;
      res_part <= '0;
      cnt      <= '0;
      c_q      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      negative <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      busy <= (state_d == BUSY);
      done <= (state_d == DONE);
      if (accept) begin
        a_sr  <= A;
        nb_sr <= ~B;
        c_q   <= 1'b1;
        cnt   <= '0;
      end else if (step) begin
        a_sr     <= a_sr >> 1;
        nb_sr    <= nb_sr >> 1;
        c_q      <= c_next;
        cnt      <= cnt + CW'(1);
        res_part <= res_next[WIDTH-1:1];
      end
      // On the final bit the MSB operand bits are still at position 0 of the shifters.
      if (last) begin
        diff     <= res_next;
        negative <= s;
        zero     <= (res_next == '0);
        carry    <= c_next;
        overflow <= (a_sr[0] == nb_sr[0]) && (s != a_sr[0]);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: 64-bit handshake/flag cases plus an
// exhaustive 4-bit sweep, checked against a scoreboard of modelled results.
module tb_serial_subtractor;

  localparam int unsigned W  = 64;
  localparam int unsigned WS = 4;

  typedef struct {
    logic [63:0] d;
    logic        n, z, c, v;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, start_s;
  logic [W-1:0]  a, b, diff;
  logic [WS-1:0] a_s, b_s, diff_s;
  logic          busy, done, negative, zero, carry, overflow;
  logic          busy_s, done_s, negative_s, zero_s, carry_s, overflow_s;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic overlap = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .diff(diff), .negative(negative),
    .zero(zero), .carry(carry), .overflow(overflow)
  );

  serial_subtractor #(.WIDTH(WS)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .A(a_s), .B(b_s),
    .busy(busy_s), .done(done_s), .diff(diff_s), .negative(negative_s),
    .zero(zero_s), .carry(carry_s), .overflow(overflow_s)
  );

  always @(negedge clk) begin
    if ((busy && done) || (busy_s && done_s)) overlap = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv, input int w);
    logic [63:0] m;
    exp_t        e;
    m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    e.d = (av - bv) & m;
    e.n = e.d[w-1];
    e.z = (e.d == 64'd0);
    e.c = ((av & m) >= (bv & m));
    e.v = (av[w-1] != bv[w-1]) && (e.d[w-1] != av[w-1]);
    return e;
  endfunction

  task automatic launch(input int w, input logic [63:0] av, input logic [63:0] bv);
    if (w == 64) begin
      a = av; b = bv; start = 1'b1;
    end else begin
      a_s = av[3:0]; b_s = bv[3:0]; start_s = 1'b1;
    end
    sb.push_back(model(av, bv, w));
    @(posedge clk); #1;
    start = 1'b0; start_s = 1'b0;
  endtask

  // Bounded wait: an expired bound shows up as a latency mismatch.
  task automatic wait_done(input string tag, input int w, input int exp_lat);
    int   lat;
    logic d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      d = (w == 64) ? done : done_s;
    end while (!d && lat < 300);
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic check_out(input string tag, input int w);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s.scoreboard: observed empty queue, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      if (w == 64) begin
        chk({tag, ".diff"}, diff,              e.d);
        chk({tag, ".N"},    64'(negative),     64'(e.n));
        chk({tag, ".Z"},    64'(zero),         64'(e.z));
        chk({tag, ".C"},    64'(carry),        64'(e.c));
        chk({tag, ".V"},    64'(overflow),     64'(e.v));
      end else begin
        chk({tag, ".diff"}, 64'(diff_s),       e.d);
        chk({tag, ".N"},    64'(negative_s),   64'(e.n));
        chk({tag, ".Z"},    64'(zero_s),       64'(e.z));
        chk({tag, ".C"},    64'(carry_s),      64'(e.c));
        chk({tag, ".V"},    64'(overflow_s),   64'(e.v));
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk({tag, ".diff"}, diff, 64'd0);
    chk({tag, ".flags"}, 64'({negative, zero, carry, overflow}), 64'd0);
    chk({tag, ".small"}, 64'({busy_s, done_s, diff_s, negative_s, zero_s, carry_s, overflow_s}), 64'd0);
  endtask

  initial begin
    logic [63:0] ta[6];
    logic [63:0] tbv[6];
    logic        seen;
    exp_t        e;

    reset = 1'b1; start = 1'b0; start_s = 1'b0;
    a = '0; b = '0; a_s = '0; b_s = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic operations, including wrap-around and overflow corners.
    ta[0] = 64'd10;                   tbv[0] = 64'd3;
    ta[1] = 64'd3;                    tbv[1] = 64'd10;
    ta[2] = 64'h1234_5678_9ABC_DEF0;  tbv[2] = 64'h1234_5678_9ABC_DEF0;
    ta[3] = 64'h8000_0000_0000_0000;  tbv[3] = 64'd1;
    ta[4] = 64'd0;                    tbv[4] = 64'd1;
    ta[5] = 64'h7FFF_FFFF_FFFF_FFFF;  tbv[5] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      launch(64, ta[i], tbv[i]);
      chk("basic.busy", 64'(busy), 64'd1);
      wait_done("basic", 64, W);
      check_out("basic", 64);
      e = model(ta[i], tbv[i], 64);
      @(posedge clk); #1;
      chk("basic.done_pulse", 64'(done), 64'd0);
      chk("basic.idle", 64'(busy), 64'd0);
      chk("basic.hold", diff, e.d);
    end

    // start mid-operation with operands changed after accept: ignored.
    launch(64, 64'd10, 64'd3);
    a = 64'd5; b = 64'd99;
    repeat (8) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("midstart", 64, W - 9);
    check_out("midstart", 64);
    @(posedge clk); #1;
    chk("midstart.no_queue", 64'(busy), 64'd0);

    // start held high: second operation accepted in the DONE cycle.
    a = 64'd100; b = 64'd1; start = 1'b1;
    sb.push_back(model(64'd100, 64'd1, 64));
    @(posedge clk); #1;
    a = 64'd1; b = 64'd100;
    sb.push_back(model(64'd1, 64'd100, 64));
    wait_done("held1", 64, W);
    check_out("held1", 64);
    @(posedge clk); #1;
    start = 1'b0;
    chk("held.rebusy", 64'(busy), 64'd1);
    wait_done("held2", 64, W);
    check_out("held2", 64);

    // Reset mid-operation with start also high: aborted, no done.
    @(posedge clk); #1;
    launch(64, 64'd7, 64'd2);
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check_reset_state("abort");
    sb.delete();  // aborted op never produces a result
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort.no_done", 64'(seen), 64'd0);
    launch(64, 64'd20, 64'd30);
    wait_done("after_abort", 64, W);
    check_out("after_abort", 64);

    // Exhaustive 4-bit sweep with post-done stability.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        launch(4, 64'(i), 64'(j));
        wait_done("exh", 4, WS);
        check_out("exh", 4);
        e = model(64'(i), 64'(j), 4);
        @(posedge clk); #1;
        chk("exh.done_pulse", 64'(done_s), 64'd0);
        chk("exh.hold", 64'({diff_s, negative_s, zero_s, carry_s, overflow_s}),
            64'({e.d[3:0], e.n, e.z, e.c, e.v}));
      end
    end

    chk("busy_done_exclusive", 64'(overlap), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
